led_frame_sequencer: RTL
========================

Name: led_frame_sequencer

Overview:
Frame-synchronous scheduler for the 18-LED on/off vector consumed by the square-wave NTSC video generator. Requesters push timed LED patterns through a valid/ready handshake into a small FIFO. The block applies each pattern only at the frame boundary pulse (HVcy), so the display never changes mid-frame, and holds each pattern for a programmed number of frames. It sits between the host/control logic and the video block's LEDs_ON input.

Parameters:
C_DEPTH, 4, FIFO depth in entries; power of two, 2..16
C_IDLE_LEDs, 18'h00000, LED vector driven after reset and after clear

Ports:
CK_i  in  1  clock (12.27272MHz)
XRST_i  in  1  synchronous active-low reset
CK_EE_i  in  1  clock enable; all non-reset state advances only when high
HVcy_i  in  1  frame boundary pulse from video block (one CK_EE cycle per frame)
CLR_i  in  1  synchronous flush request
CMD_VALID_i  in  1  command valid
CMD_READY_o  out  1  command accepted when high together with VALID and CK_EE_i
CMD_LEDs_i  in  18  LED pattern to display
CMD_HOLDs_i  in  8  frames to hold the pattern; 0 is treated as 1
LEDs_ON_o  out  18  registered LED vector to video block
BUSY_o  out  1  pattern in progress or FIFO non-empty
FIFO_CNTs_o  out  $clog2(C_DEPTH)+1  current FIFO occupancy
UNDERRUN_o  out  1  one-cycle pulse: hold expired with FIFO empty

Behaviour:
- Reset (XRST_i low at a CK_i edge, independent of CK_EE_i): LEDs_ON_o=C_IDLE_LEDs, FIFO empty, FIFO_CNTs_o=0, state IDLE, hold counter 0, UNDERRUN_o=0, BUSY_o=0. CMD_READY_o=1 from the first cycle after reset.
- tick = HVcy_i & CK_EE_i. push = CMD_VALID_i & CMD_READY_o & CK_EE_i.
- CMD_READY_o = (FIFO_CNTs_o != C_DEPTH). It is combinational from the registered count. A pop on the same cycle does not free a slot for a push on that cycle.
- FIFO entry is {CMD_LEDs_i, CMD_HOLDs_i}. Pointers wrap modulo C_DEPTH. Push and pop in the same cycle leave the count unchanged.
- States:
  - IDLE: LEDs_ON_o holds its last value. On tick with count>0: pop the head, load LEDs_ON_o, set HOLD=max(holds,1)-1, go to SHOW. On tick with count=0: stay in IDLE, no pulse.
  - SHOW, on tick:
    - HOLD!=0: HOLD-=1.
    - HOLD=0 and count>0: pop, load the new pattern and HOLD, stay in SHOW.
    - HOLD=0 and count=0: keep LEDs_ON_o, pulse UNDERRUN_o, go to IDLE.
- Latency: LEDs_ON_o changes at the CK_i edge that samples tick (one cycle after the HVcy_i edge). A pattern with holds=N is visible for exactly N frames when the next entry is already queued.
- An entry pushed on the same cycle as a tick is not eligible for that tick, because pop eligibility uses the registered count.
- CLR_i & CK_EE_i: flush the FIFO (count=0), LEDs_ON_o=C_IDLE_LEDs, HOLD=0, state IDLE, no UNDERRUN pulse. CLR has priority over a simultaneous push and tick; both are ignored that cycle. CMD_READY_o stays high.
- CK_EE_i low: all state frozen; UNDERRUN_o is deasserted.
- BUSY_o = (state==SHOW) | (count!=0), registered-derived, with no combinational path from inputs.
- Reset mid-pattern aborts immediately. Entries in flight are discarded.

Test Plan:
- Reset → LEDs_ON_o=0, FIFO_CNTs_o=0, CMD_READY_o=1, BUSY_o=0; 3 ticks with empty FIFO → no change and no UNDERRUN pulse.
- Push {18'h3FFFF,holds=2} then {18'h00001,holds=1}, apply 4 ticks → LEDs_ON_o: 3FFFF after tick1, 3FFFF after tick2, 00001 after tick3, unchanged after tick4 with UNDERRUN_o pulse on tick4, then state IDLE and BUSY_o=0.
- holds=0 entry followed by a second entry → each pattern is shown for exactly 1 frame.
- Fill 4 entries with C_DEPTH=4 → CMD_READY_o=0 and a 5th VALID is not accepted; a tick pops one entry, READY rises the next cycle, and the pending push then completes; total of 5 patterns displayed in order.
- Push and tick in the same cycle from the empty state → pattern is not loaded on that tick; it loads on the next tick.
- CLR_i asserted with 3 entries queued, concurrent with a push and a tick → FIFO_CNTs_o=0, LEDs_ON_o=C_IDLE_LEDs, pushed entry lost; CK_EE_i=0 during a tick → no state change.

Source files
------------

// File: rtl/led_cmd_if.sv
// LED command channel between a requester and led_frame_sequencer.
//
// Handshake: a command transfers on a clock-enabled cycle where valid and
// ready are both high. ready depends only on registered state, so a
// requester may hold valid and its payload steady until it sees ready.
//
// Signals:
//   valid  requester has a command
//   ready  sequencer can accept a command this cycle
//   leds   18-bit LED on/off pattern
//   holds  number of frames to show the pattern (0 behaves as 1)
interface led_cmd_if;
  logic        valid;
  logic        ready;
  logic [17:0] leds;
  logic [7:0]  holds;

  modport master (output valid, output leds, output holds, input ready);
  modport slave  (input valid, input leds, input holds, output ready);
endinterface

// File: rtl/led_frame_sequencer.sv
// Frame-synchronous LED pattern scheduler. Commands are queued in a small
// FIFO and applied only on frame boundary ticks (HVcy_i & CK_EE_i), each
// held for a programmed number of frames.
//
// Ports:
//   CK_i          clock
//   XRST_i        synchronous active-low reset
//   CK_EE_i       clock enable for all non-reset state
//   HVcy_i        frame boundary pulse
//   CLR_i         synchronous flush (qualified by CK_EE_i)
//   cmd           command channel (slave side)
//   LEDs_ON_o     registered LED vector to the video block
//   BUSY_o        pattern in progress or FIFO non-empty
//   FIFO_CNTs_o   FIFO occupancy
//   UNDERRUN_o    one-cycle pulse: hold expired with nothing queued
//   STATE_DBG_o   current FSM state (0 = IDLE, 1 = SHOW)
module led_frame_sequencer #(
  parameter int          C_DEPTH     = 4,
  parameter logic [17:0] C_IDLE_LEDs = 18'h00000
) (
  input  logic                     CK_i,
  input  logic                     XRST_i,
  input  logic                     CK_EE_i,
  input  logic                     HVcy_i,
  input  logic                     CLR_i,
  led_cmd_if.slave                 cmd,
  output logic [17:0]              LEDs_ON_o,
  output logic                     BUSY_o,
  output logic [$clog2(C_DEPTH):0] FIFO_CNTs_o,
  output logic                     UNDERRUN_o,
  output logic                     STATE_DBG_o
);

  localparam int PW = $clog2(C_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(C_DEPTH);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [17:0]   leds_q, leds_d;
  logic          underrun_q, underrun_d;

  logic [25:0]   mem [C_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  logic          clr, tick, push, pop;
  logic [17:0]   head_leds;
  logic [7:0]    head_holds;
  logic [7:0]    head_hold_init;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not make room for a push.
  assign cmd.ready = (cnt != FULL);

  // Flush wins over tick and push in the same cycle.
  assign clr  = CLR_i & CK_EE_i;
  assign tick = HVcy_i & CK_EE_i & ~clr;
  assign push = cmd.valid & cmd.ready & CK_EE_i & ~clr;

  assign {head_leds, head_holds} = mem[rd_ptr];
  // HOLD counts remaining extra frames, so holds=N shows N frames.
  assign head_hold_init = (head_holds == 8'd0) ? 8'd0 : head_holds - 8'd1;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    leds_d     = leds_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      hold_d  = 8'd0;
      leds_d  = C_IDLE_LEDs;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (cnt != '0) begin
            pop     = 1'b1;
            leds_d  = head_leds;
            hold_d  = head_hold_init;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end else if (cnt != '0) begin
            pop    = 1'b1;
            leds_d = head_leds;
            hold_d = head_hold_init;
          end else begin
            underrun_d = 1'b1;
            state_d    = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XRST_i) begin
      state_q    <= IDLE;
      hold_q     <= 8'd0;
      leds_q     <= C_IDLE_LEDs;
      underrun_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
    end else begin
      // With CK_EE_i low the next-state logic holds everything and
      // underrun_d is 0, so the pulse drops while frozen.
      state_q    <= state_d;
      hold_q     <= hold_d;
      leds_q     <= leds_d;
      underrun_q <= underrun_d;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge CK_i) begin
    if (push) mem[wr_ptr] <= {cmd.leds, cmd.holds};
  end

  assign LEDs_ON_o   = leds_q;
  assign FIFO_CNTs_o = cnt;
  assign UNDERRUN_o  = underrun_q;
  assign BUSY_o      = (state_q == SHOW) | (cnt != '0);
  assign STATE_DBG_o = state_q;

endmodule
